pc_seq_ctrl: RTL and testbench

- Sequencer that owns the architectural fetch PC and the decode/execute PC shadow registers (dpc, epc) for the 5-stage MIPS pipeline.
- Arbitrates between four events each cycle: execute-stage redirects (taken branch / jump), multi-cycle stall requests from the hazard unit, instruction-memory back-pressure, and normal sequential advance.
- Enforces the MIPS single delay slot: the decode-stage instruction survives a redirect; the fetch-stage instruction is flushed.
- Feeds the combinational branch/jump target logic with its epc/dpc and receives the resolved target back.

---
 rtl/mips_pkg.sv | 14 +
 rtl/sat_counter.sv | 20 ++
 rtl/pc_seq_ctrl.sv | 144 ++++++++++++++
 tb/tb_pc_seq_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the fetch-PC sequencer: state encoding and PC constants.
package mips_pkg;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2,
    S_WAIT  = 2'd3
  } seq_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0100_0000;
  localparam logic [31:0] PC_INC           = 32'd4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count increment requests, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pc_seq_ctrl.sv
// Fetch-PC sequencer: owns pc/dpc/epc and arbitrates redirect, stall,
// imem back-pressure and sequential advance for the 5-stage pipeline.
module pc_seq_ctrl
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned STALL_W  = 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               w_redirect_valid,
  input  logic [31:0]        w_redirect_target_32,
  input  logic               w_stall_req,
  input  logic [STALL_W-1:0] w_stall_cycles,
  input  logic               w_imem_ready,
  output logic [31:0]        w_pc_32,
  output logic [31:0]        w_dpc_32,
  output logic [31:0]        w_epc_32,
  output logic               w_fetch_valid,
  output logic               w_flush,
  output logic               w_stalled,
  output logic [CNT_W-1:0]   w_redirect_cnt
);

  seq_state_t         state, state_nx;
  logic [STALL_W-1:0] scnt, scnt_nx;
  logic [31:0]        pc_nx, dpc_nx, epc_nx;
  logic               fv_nx;
  logic               redirect_take;

  // Next-state, next-PC and redirect decision for the current cycle.
  always_comb begin
    state_nx      = state;
    scnt_nx       = scnt;
    pc_nx         = w_pc_32;
    dpc_nx        = w_dpc_32;
    epc_nx        = w_epc_32;
    fv_nx         = w_fetch_valid;
    redirect_take = 1'b0;

    unique case (state)
      S_BOOT: begin
        state_nx = S_RUN;
        fv_nx    = 1'b1;
      end

      S_RUN: begin
        if (w_redirect_valid) begin
          redirect_take = 1'b1;
          pc_nx         = w_redirect_target_32;
          dpc_nx        = w_pc_32;
          epc_nx        = w_dpc_32;
          state_nx      = w_imem_ready ? S_RUN : S_WAIT;
        end else if (w_stall_req) begin
          scnt_nx  = (w_stall_cycles == '0) ? '0 : w_stall_cycles - STALL_W'(1);
          state_nx = S_STALL;
        end else if (!w_imem_ready) begin
          state_nx = S_WAIT;
        end else begin
          pc_nx  = w_pc_32 + PC_INC;
          dpc_nx = w_pc_32;
          epc_nx = w_dpc_32;
        end
      end

      // The final stall cycle (counter at 0) already advances, so the PCs
      // stay frozen for exactly the requested number of cycles.
      S_STALL: begin
        if (w_redirect_valid) begin
          redirect_take = 1'b1;
          pc_nx         = w_redirect_target_32;
          dpc_nx        = w_pc_32;
          epc_nx        = w_dpc_32;
          scnt_nx       = '0;
          state_nx      = w_imem_ready ? S_RUN : S_WAIT;
        end else if (scnt == '0) begin
          if (w_imem_ready) begin
            pc_nx    = w_pc_32 + PC_INC;
            dpc_nx   = w_pc_32;
            epc_nx   = w_dpc_32;
            state_nx = S_RUN;
          end else begin
            state_nx = S_WAIT;
          end
        end else begin
          scnt_nx = scnt - STALL_W'(1);
        end
      end

      // While imem is busy only the fetch address retargets; decode/execute
      // shadows move once the fetch is actually accepted.
      S_WAIT: begin
        if (w_imem_ready) begin
          state_nx = S_RUN;
          dpc_nx   = w_pc_32;
          epc_nx   = w_dpc_32;
          if (w_redirect_valid) begin
            redirect_take = 1'b1;
            pc_nx         = w_redirect_target_32;
          end else begin
            pc_nx = w_pc_32 + PC_INC;
          end
        end else if (w_redirect_valid) begin
          redirect_take = 1'b1;
          pc_nx         = w_redirect_target_32;
        end
      end

      default: state_nx = S_BOOT;
    endcase
  end

  // Register state and all sequencer outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= S_BOOT;
      scnt          <= '0;
      w_pc_32       <= RESET_PC;
      w_dpc_32      <= '0;
      w_epc_32      <= '0;
      w_fetch_valid <= 1'b0;
      w_flush       <= 1'b0;
      w_stalled     <= 1'b0;
    end else begin
      state         <= state_nx;
      scnt          <= scnt_nx;
      w_pc_32       <= pc_nx;
      w_dpc_32      <= dpc_nx;
      w_epc_32      <= epc_nx;
      w_fetch_valid <= fv_nx;
      w_flush       <= redirect_take;
      w_stalled     <= (state_nx == S_STALL) || (state_nx == S_WAIT);
    end
  end

  sat_counter #(.W(CNT_W)) u_redirect_cnt (
    .clk   (clock),
    .rst_n (reset),
    .inc   (redirect_take),
    .count (w_redirect_cnt)
  );

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Self-checking bench for pc_seq_ctrl: directed scenarios, random traffic
// with async resets, and redirect-counter saturation, all against a
// behavioural model of the sequencing rules.
module tb_pc_seq_ctrl;

  localparam logic [31:0] RST_PC  = 32'h0100_0000;
  localparam int unsigned CNT_MAX = 65535;

  logic        clock;
  logic        reset;
  logic        redir;
  logic [31:0] tgt;
  logic        sreq;
  logic [1:0]  scyc;
  logic        rdy;
  logic [31:0] pc, dpc, epc;
  logic        fv, flush, stalled;
  logic [15:0] rcnt;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  pc_seq_ctrl #(.RESET_PC(RST_PC), .STALL_W(2), .CNT_W(16)) dut (
    .clock                (clock),
    .reset                (reset),
    .w_redirect_valid     (redir),
    .w_redirect_target_32 (tgt),
    .w_stall_req          (sreq),
    .w_stall_cycles       (scyc),
    .w_imem_ready         (rdy),
    .w_pc_32              (pc),
    .w_dpc_32             (dpc),
    .w_epc_32             (epc),
    .w_fetch_valid        (fv),
    .w_flush              (flush),
    .w_stalled            (stalled),
    .w_redirect_cnt       (rcnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural model: pipeline mode kept as "cycles still frozen" plus a
  // "waiting on memory" flag.
  logic [31:0] m_pc, m_dpc, m_epc;
  bit          m_fv, m_flush, m_booted, m_wait;
  int          m_freeze;
  int unsigned m_rcnt;

  task automatic m_reset();
    m_pc = RST_PC; m_dpc = '0; m_epc = '0;
    m_fv = 0; m_flush = 0; m_booted = 0; m_wait = 0;
    m_freeze = 0; m_rcnt = 0;
  endtask

  task automatic m_count();
    if (m_rcnt < CNT_MAX) m_rcnt++;
    m_flush = 1;
  endtask

  task automatic m_redirect();
    m_epc = m_dpc; m_dpc = m_pc; m_pc = tgt;
    m_count();
  endtask

  task automatic m_advance();
    m_epc = m_dpc; m_dpc = m_pc; m_pc = m_pc + 32'd4;
  endtask

  task automatic m_update();
    m_flush = 0;
    if (!m_booted) begin
      m_booted = 1; m_fv = 1;
    end else if (m_freeze > 0) begin
      if (redir) begin
        m_redirect(); m_freeze = 0; m_wait = !rdy;
      end else if (m_freeze == 1) begin
        m_freeze = 0;
        if (rdy) m_advance(); else m_wait = 1;
      end else begin
        m_freeze--;
      end
    end else if (m_wait) begin
      if (rdy) begin
        if (redir) m_redirect(); else m_advance();
        m_wait = 0;
      end else if (redir) begin
        m_pc = tgt; m_count();
      end
    end else begin
      if (redir) begin
        m_redirect(); m_wait = !rdy;
      end else if (sreq) begin
        m_freeze = (scyc == 0) ? 1 : int'(scyc);
      end else if (!rdy) begin
        m_wait = 1;
      end else begin
        m_advance();
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d: observed 0x%0h expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("pc",      pc,               m_pc);
    chk("dpc",     dpc,              m_dpc);
    chk("epc",     epc,              m_epc);
    chk("fv",      32'(fv),          32'(m_fv));
    chk("flush",   32'(flush),       32'(m_flush));
    chk("stalled", 32'(stalled),     32'((m_freeze > 0) || m_wait));
    chk("rcnt",    32'(rcnt),        m_rcnt);
  endtask

  task automatic step();
    @(posedge clock);
    cyc++;
    if (!reset) m_reset(); else m_update();
    #1;
    chk_all();
  endtask

  initial begin
    reset = 1'b0; redir = 1'b0; tgt = '0; sreq = 1'b0; scyc = '0; rdy = 1'b1;
    m_reset();

    // Reset state
    step(); step();
    chk("rst_pc", pc, RST_PC);
    chk("rst_fv", 32'(fv), 32'd0);
    chk("rst_cnt", 32'(rcnt), 32'd0);
    reset = 1'b1;
    #1;
    chk("boot_pc", pc, RST_PC);
    chk("boot_fv", 32'(fv), 32'd0);

    // Boot and sequential advance
    step();
    chk("run0_pc", pc, RST_PC);
    chk("run0_fv", 32'(fv), 32'd1);
    step();
    chk("adv_pc4", pc, 32'h0100_0004);
    step();
    chk("adv_pc8", pc, 32'h0100_0008);
    chk("dpc_lag", dpc, 32'h0100_0004);
    chk("epc_lag", epc, 32'h0100_0000);

    // Stall of 3 cycles at pc=0x0100_0008
    sreq = 1'b1; scyc = 2'd3;
    step();
    sreq = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      chk("stall3_pc", pc, 32'h0100_0008);
      chk("stall3_st", 32'(stalled), 32'd1);
    end
    step();
    chk("stall3_out", pc, 32'h0100_000C);
    chk("stall3_clr", 32'(stalled), 32'd0);

    // Stall length 0 behaves as 1
    sreq = 1'b1; scyc = 2'd0;
    step();
    sreq = 1'b0;
    chk("stall0_st", 32'(stalled), 32'd1);
    chk("stall0_pc", pc, 32'h0100_000C);
    step();
    chk("stall0_out", pc, 32'h0100_0010);
    chk("stall0_clr", 32'(stalled), 32'd0);

    // Redirect at pc=0x0100_0010
    redir = 1'b1; tgt = 32'h0040_0020;
    step();
    redir = 1'b0;
    chk("redir_pc", pc, 32'h0040_0020);
    chk("redir_dpc", dpc, 32'h0100_0010);
    chk("redir_flush", 32'(flush), 32'd1);
    chk("redir_cnt", 32'(rcnt), 32'd1);
    step();
    chk("redir_flush1", 32'(flush), 32'd0);
    chk("redir_adv", pc, 32'h0040_0024);

    // Redirect in second stall cycle aborts the stall
    sreq = 1'b1; scyc = 2'd3;
    step();
    sreq = 1'b0;
    step();
    redir = 1'b1; tgt = 32'h0000_1000;
    step();
    redir = 1'b0;
    chk("abort_pc", pc, 32'h0000_1000);
    chk("abort_st", 32'(stalled), 32'd0);
    step();
    chk("abort_adv", pc, 32'h0000_1004);

    // imem busy 4 cycles at pc=0x0100_0004 with redirect in the 2nd
    redir = 1'b1; tgt = 32'h0100_0004;
    step();
    redir = 1'b0; rdy = 1'b0;
    step();
    chk("wait_pc", pc, 32'h0100_0004);
    chk("wait_st", 32'(stalled), 32'd1);
    redir = 1'b1; tgt = 32'h0000_2000;
    step();
    redir = 1'b0;
    chk("wait_rd_pc", pc, 32'h0000_2000);
    chk("wait_rd_fl", 32'(flush), 32'd1);
    chk("wait_rd_st", 32'(stalled), 32'd1);
    step();
    step();
    chk("wait_hold", pc, 32'h0000_2000);
    rdy = 1'b1;
    step();
    chk("wait_done", pc, 32'h0000_2004);
    chk("wait_clr", 32'(stalled), 32'd0);

    // Wrap-around past the top of the address space
    redir = 1'b1; tgt = 32'hFFFF_FFF8;
    step();
    redir = 1'b0;
    step();
    chk("wrap_fffc", pc, 32'hFFFF_FFFC);
    step();
    chk("wrap_zero", pc, 32'h0000_0000);

    // Random traffic with occasional asynchronous reset
    for (int i = 0; i < 3000; i++) begin
      redir = ($urandom_range(0, 7) == 0);
      tgt   = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 15) == 0) tgt = 32'hFFFF_FFF8;
      sreq  = ($urandom_range(0, 5) == 0);
      scyc  = 2'($urandom_range(0, 3));
      rdy   = ($urandom_range(0, 4) != 0);
      if (i % 700 == 350) begin
        #2;
        reset = 1'b0;
        m_reset();
        #1;
        chk_all();
        step();
        reset = 1'b1;
      end else begin
        step();
      end
    end

    // Redirect counter saturation
    sreq = 1'b0; rdy = 1'b1; redir = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      tgt = 32'h0000_4000 + 32'(i) * 32'd4;
      step();
    end
    chk("sat_cnt", 32'(rcnt), 32'h0000_FFFF);
    step();
    chk("sat_hold", 32'(rcnt), 32'h0000_FFFF);
    redir = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
